// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_sequencer
// Purpose  : Multi-cycle controller for the mult (4'b0010) and div (4'b0011)
//            ALU ops. It runs an iterative shift-add multiply or a restoring
//            divide, one bit per cycle, and produces the HI/LO result pair.
//            While it works it holds busy high so the pipeline stalls issue.
// Ports    : clk, resetn (async, active low)
//            start, alu_control[3:0], signed_op, op_a, op_b  - request
//            flush                                           - abort in-flight op
//            busy, done, div_zero                            - status
//            hi, lo                                          - result pair
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0]       c_OP_MULT = 4'b0010;
  localparam logic [3:0]       c_OP_DIV  = 4'b0011;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_divz;
  logic             r_neg_hi;     // product sign (mult) / remainder sign (div)
  logic             r_neg_lo;     // product sign (mult) / quotient sign (div)
  logic [WIDTH-1:0] r_opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_acc_hi;     // partial product high / partial remainder
  logic [WIDTH-1:0] r_acc_lo;     // multiplier bits / dividend -> quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_is_div;
  logic             w_divz;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // Request decode: only IDLE/DONE listen to start.
  assign w_is_div = (alu_control == c_OP_DIV);
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start &&
                    ((alu_control == c_OP_MULT) || w_is_div);
  assign w_divz   = w_is_div && (op_b == '0);

  assign w_sign_a = signed_op & op_a[WIDTH-1];
  assign w_sign_b = signed_op & op_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -op_a : op_a;
  assign w_mag_b  = w_sign_b ? -op_b : op_b;

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole 2W+1-bit value right.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

  // Restoring step: bring in the next dividend bit, try the subtraction,
  // keep it only if it did not borrow.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

  // Sign fix-up. The product is negated as one 2W-bit quantity.
  assign w_prod_neg = -{r_acc_hi, r_acc_lo};

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (r_divz) begin
      w_fix_hi = r_acc_hi;
      w_fix_lo = r_acc_lo;
    end else if (!r_is_div) begin
      if (r_neg_lo) begin
        w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_neg[WIDTH-1:0];
      end
    end else begin
      w_fix_hi = r_neg_hi ? -r_acc_hi : r_acc_hi;
      w_fix_lo = r_neg_lo ? -r_acc_lo : r_acc_lo;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    div_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_divz ? S_FIX : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)                  w_next = S_IDLE;
        else if (r_cnt == c_CNT_ONE) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        div_zero = r_divz;
        if (w_accept) w_next = w_divz ? S_FIX : S_CALC;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_divz   <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_is_div <= w_is_div;
        r_divz   <= w_divz;
        r_neg_lo <= w_sign_a ^ w_sign_b;
        r_neg_hi <= w_is_div ? w_sign_a : (w_sign_a ^ w_sign_b);
        if (w_divz) begin
          // Divide by zero: result is fixed, no iterations needed.
          r_opnd   <= '0;
          r_acc_hi <= op_a;
          r_acc_lo <= '1;
        end else if (w_is_div) begin
          r_opnd   <= w_mag_b;
          r_acc_hi <= '0;
          r_acc_lo <= w_mag_a;
        end else begin
          r_opnd   <= w_mag_a;
          r_acc_hi <= '0;
          r_acc_lo <= w_mag_b;
        end
      end else if ((r_state == S_CALC) && !flush) begin
        r_cnt <= r_cnt - c_CNT_ONE;
        if (r_is_div) begin
          if (!w_div_diff[WIDTH]) begin
            r_acc_hi <= w_div_diff[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_hi <= w_div_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          r_acc_hi <= w_mul_sum[WIDTH:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
      end

      // Results only move on a completed FIX; a flushed op leaves them alone.
      if ((r_state == S_FIX) && !flush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_sequencer
// Purpose  : Directed self-checking bench for alu_muldiv_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_sequencer;

  localparam logic [3:0] c_MULT = 4'b0010;
  localparam logic [3:0] c_DIV  = 4'b0011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  alu_control;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  int edges;
  int bcnt;
  bit seen_done;

  alu_muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .alu_control (alu_control),
    .signed_op   (signed_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait for done. Returns the number of rising edges from
  // the accept edge (counted as 1) to the edge after which done is seen, and
  // the number of sampled cycles with busy high in between. With now=1 the
  // request is driven in the current (DONE) cycle for back-to-back issue.
  task automatic run_op(input bit now, input logic [3:0] code, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        output int n_edges, output int n_busy);
    if (!now) @(negedge clk);
    start = 1'b1; alu_control = code; signed_op = sgn; op_a = a; op_b = b;
    @(posedge clk);
    n_edges = 1;
    n_busy  = 0;
    #1;
    start = 1'b0; flush = 1'b0;
    op_a = ~a; op_b = ~b; signed_op = ~sgn;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy) n_busy++;
      @(posedge clk);
      n_edges++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; alu_control = 4'b0000; signed_op = 1'b0;
    op_a = '0; op_b = '0; flush = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;

    // Unsigned mult, full-scale operands
    run_op(1'b0, c_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcnt);
    check("umul_lat",  64'(edges), 64'd34);
    check("umul_busy", 64'(bcnt), 64'd33);
    check("umul_res",  {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("umul_dz",   64'(div_zero), 64'd0);

    // Signed mult -3 x 5
    run_op(1'b0, c_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, edges, bcnt);
    check("smul_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Signed div -7 / 2: q = -3, r = -1
    run_op(1'b0, c_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, edges, bcnt);
    check("sdiv_lat", 64'(edges), 64'd34);
    check("sdiv_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Overflow case -2^31 / -1
    run_op(1'b0, c_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcnt);
    check("ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);
    check("ovf_dz",  64'(div_zero), 64'd0);

    // Divide by zero
    run_op(1'b0, c_DIV, 1'b0, 32'h0000_1234, 32'd0, edges, bcnt);
    check("dz_lat", 64'(edges), 64'd2);
    check("dz_flag", 64'(div_zero), 64'd1);
    check("dz_res", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    @(negedge clk);
    check("dz_flag_clr", 64'(div_zero), 64'd0);
    check("dz_done_clr", 64'(done), 64'd0);

    // Back-to-back: div issued in DONE cycle, with flush also high (start wins)
    run_op(1'b0, c_MULT, 1'b0, 32'd2, 32'd3, edges, bcnt);
    check("b2b_first", {hi, lo}, 64'd6);
    flush = 1'b1;
    run_op(1'b1, c_DIV, 1'b0, 32'd100, 32'd7, edges, bcnt);
    check("b2b_lat", 64'(edges), 64'd34);
    check("b2b_res", {hi, lo}, {32'd2, 32'd14});

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; alu_control = c_MULT; signed_op = 1'b0; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    repeat (3) begin @(posedge clk); edges++; end
    @(negedge clk);
    start = 1'b1; alu_control = c_DIV; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk);
    edges++;
    #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      edges++;
    end
    check("ign_lat", 64'(edges), 64'd34);
    check("ign_res", {hi, lo}, 64'd25);

    // Non-mult/div code with start is ignored
    @(negedge clk);
    start = 1'b1; alu_control = 4'b0000; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("bad_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("bad_busy2", 64'(busy), 64'd0);
    check("bad_done", 64'(done), 64'd0);

    // Flush at CALC cycle 5 of 6 x 7
    @(negedge clk);
    start = 1'b1; alu_control = c_MULT; signed_op = 1'b0; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fl_busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("fl_nodone", 64'(seen_done), 64'd0);
    check("fl_hold", {hi, lo}, 64'd25);
    run_op(1'b0, c_MULT, 1'b0, 32'd6, 32'd7, edges, bcnt);
    check("fl_redo", {hi, lo}, 64'd42);

    // Reset mid-CALC (cycle 10), then 3 x 3
    @(negedge clk);
    start = 1'b1; alu_control = c_MULT; signed_op = 1'b0; op_a = 32'h11; op_b = 32'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(1'b0, c_MULT, 1'b0, 32'd3, 32'd3, edges, bcnt);
    check("mrst_lat", 64'(edges), 64'd34);
    check("mrst_res", {hi, lo}, 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
